// File: rtl/psram_quad_ctrl.sv
// psram_quad_ctrl
//   QPI controller for an APS6404L-class 64 Mbit PSRAM. After reset it waits
//   INIT_CYCLES, then sends reset-enable (0x66), reset (0x99) and enter-QPI
//   (0x35) in SPI mode. After that it serves one 16-bit read or write per
//   quad_start pulse. Read data goes back through rd_data with a send_uart pulse.
//
// Ports
//   sys_clk, sys_rst_n   clock, async active-low reset
//   quad_start           one-cycle request; cmd_read/address/wr_data sampled with it
//   rd_data, send_uart   last read word, one-cycle pulse when it updates
//   wr_done              one-cycle pulse when a write completes
//   busy, init_done      controller busy / PSRAM in QPI mode
//   psram_ce_n/sclk      chip enable (active low) and SPI clock (sys_clk/2)
//   psram_sio_out/oe/in  quad data lines; the tristate buffers live above this block
//
// state       | meaning
// ------------+-------------------------------------------------
// INIT_WAIT   | power-up delay of INIT_CYCLES
// INIT_CMD    | shift one init opcode out on sio[0], SPI mode
// INIT_GAP    | ce_n high CE_HIGH_MIN cycles between init opcodes
// IDLE        | ready, waiting for quad_start
// CMD         | two opcode nibbles (0xEB read / 0x38 write)
// ADDR        | six address nibbles
// WAIT        | READ_WAIT_CLKS turnaround SCLKs, bus released
// WR_DATA     | four write-data nibbles
// RD_DATA     | four read-data nibbles captured
// DONE        | ce_n high recovery, then back to IDLE
module psram_quad_ctrl #(
   parameter int INIT_CYCLES    = 4050,
   parameter int READ_WAIT_CLKS = 6,
   parameter int CE_HIGH_MIN    = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        quad_start,
   input  logic        cmd_read,
   input  logic [22:0] address,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   output logic        send_uart,
   output logic        wr_done,
   output logic        busy,
   output logic        init_done,
   output logic        psram_ce_n,
   output logic        psram_sclk,
   output logic [3:0]  psram_sio_out,
   output logic [3:0]  psram_sio_oe,
   input  logic [3:0]  psram_sio_in
);

   localparam logic [3:0] S_INIT_WAIT = 4'd0;
   localparam logic [3:0] S_INIT_CMD  = 4'd1;
   localparam logic [3:0] S_INIT_GAP  = 4'd2;
   localparam logic [3:0] S_IDLE      = 4'd3;
   localparam logic [3:0] S_CMD       = 4'd4;
   localparam logic [3:0] S_ADDR      = 4'd5;
   localparam logic [3:0] S_WAIT      = 4'd6;
   localparam logic [3:0] S_WR_DATA   = 4'd7;
   localparam logic [3:0] S_RD_DATA   = 4'd8;
   localparam logic [3:0] S_DONE      = 4'd9;

   localparam int                WAIT_W   = $clog2(INIT_CYCLES + CE_HIGH_MIN + 1);
   localparam logic [WAIT_W-1:0] INIT_TC  = WAIT_W'(INIT_CYCLES - 1);
   localparam logic [WAIT_W-1:0] GAP_TC   = WAIT_W'(CE_HIGH_MIN - 1);
   localparam logic [3:0]        RWAIT_TC = 4'(READ_WAIT_CLKS - 1);
   localparam logic [7:0]        OP_READ  = 8'hEB;
   localparam logic [7:0]        OP_WRITE = 8'h38;

   logic [3:0]        state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [3:0]        sclk_cnt;
   logic [1:0]        init_idx;
   logic              sclk_q;
   logic              qpi_mode;
   logic              is_read;
   logic [31:0]       tx_sh;
   logic [15:0]       wdata_q;
   logic [11:0]       rx_sh;
   logic              step;

   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h66;
         2'd1:    return 8'h99;
         default: return 8'h35;
      endcase
   endfunction

   // step marks the sys_clk edge that ends SCLK high: the point where
   // input data is captured and the next bit/nibble is presented.
   assign step          = ~psram_ce_n & sclk_q;
   assign psram_sclk    = sclk_q;
   // The outgoing bit/nibble always sits at the top of tx_sh.
   assign psram_sio_out = qpi_mode ? tx_sh[31:28] : {3'b000, tx_sh[31]};

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= S_INIT_WAIT;
         wait_cnt     <= '0;
         sclk_cnt     <= '0;
         init_idx     <= '0;
         sclk_q       <= 1'b0;
         qpi_mode     <= 1'b0;
         is_read      <= 1'b0;
         tx_sh        <= '0;
         wdata_q      <= '0;
         rx_sh        <= '0;
         psram_ce_n   <= 1'b1;
         psram_sio_oe <= 4'h0;
         rd_data      <= '0;
         send_uart    <= 1'b0;
         wr_done      <= 1'b0;
         busy         <= 1'b1;
         init_done    <= 1'b0;
      end else begin
         send_uart <= 1'b0;
         wr_done   <= 1'b0;
         // SCLK runs only while the chip is selected; it is low on the first
         // selected cycle and falls back to 0 when ce_n rises.
         sclk_q    <= psram_ce_n ? 1'b0 : ~sclk_q;

         case (state)
            S_INIT_WAIT: begin
               if (wait_cnt == INIT_TC) begin
                  wait_cnt     <= '0;
                  sclk_cnt     <= '0;
                  qpi_mode     <= 1'b0;
                  tx_sh        <= {init_byte(init_idx), 24'h0};
                  psram_ce_n   <= 1'b0;
                  psram_sio_oe <= 4'b0001;
                  state        <= S_INIT_CMD;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            S_INIT_CMD: begin
               if (step) begin
                  tx_sh    <= {tx_sh[30:0], 1'b0};
                  sclk_cnt <= sclk_cnt + 4'd1;
                  if (sclk_cnt == 4'd7) begin
                     psram_ce_n   <= 1'b1;
                     psram_sio_oe <= 4'h0;
                     wait_cnt     <= '0;
                     state        <= S_INIT_GAP;
                  end
               end
            end

            S_INIT_GAP: begin
               if (wait_cnt == GAP_TC) begin
                  wait_cnt <= '0;
                  if (init_idx == 2'd2) begin
                     init_done <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end else begin
                     init_idx     <= init_idx + 2'd1;
                     sclk_cnt     <= '0;
                     tx_sh        <= {init_byte(init_idx + 2'd1), 24'h0};
                     psram_ce_n   <= 1'b0;
                     psram_sio_oe <= 4'b0001;
                     state        <= S_INIT_CMD;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            S_IDLE: begin
               if (quad_start) begin
                  is_read      <= cmd_read;
                  wdata_q      <= wr_data;
                  tx_sh        <= {(cmd_read ? OP_READ : OP_WRITE), 1'b0, address};
                  qpi_mode     <= 1'b1;
                  sclk_cnt     <= '0;
                  busy         <= 1'b1;
                  psram_ce_n   <= 1'b0;
                  psram_sio_oe <= 4'hF;
                  state        <= S_CMD;
               end
            end

            S_CMD: begin
               if (step) begin
                  tx_sh    <= {tx_sh[27:0], 4'h0};
                  sclk_cnt <= sclk_cnt + 4'd1;
                  if (sclk_cnt == 4'd1) begin
                     sclk_cnt <= '0;
                     state    <= S_ADDR;
                  end
               end
            end

            S_ADDR: begin
               if (step) begin
                  tx_sh    <= {tx_sh[27:0], 4'h0};
                  sclk_cnt <= sclk_cnt + 4'd1;
                  if (sclk_cnt == 4'd5) begin
                     sclk_cnt <= '0;
                     if (is_read) begin
                        psram_sio_oe <= 4'h0;
                        state        <= S_WAIT;
                     end else begin
                        tx_sh <= {wdata_q, 16'h0};
                        state <= S_WR_DATA;
                     end
                  end
               end
            end

            S_WAIT: begin
               if (step) begin
                  sclk_cnt <= sclk_cnt + 4'd1;
                  if (sclk_cnt == RWAIT_TC) begin
                     sclk_cnt <= '0;
                     state    <= S_RD_DATA;
                  end
               end
            end

            S_WR_DATA: begin
               if (step) begin
                  tx_sh    <= {tx_sh[27:0], 4'h0};
                  sclk_cnt <= sclk_cnt + 4'd1;
                  if (sclk_cnt == 4'd3) begin
                     psram_ce_n   <= 1'b1;
                     psram_sio_oe <= 4'h0;
                     wr_done      <= 1'b1;
                     wait_cnt     <= '0;
                     state        <= S_DONE;
                  end
               end
            end

            S_RD_DATA: begin
               if (step) begin
                  rx_sh    <= {rx_sh[7:0], psram_sio_in};
                  sclk_cnt <= sclk_cnt + 4'd1;
                  if (sclk_cnt == 4'd3) begin
                     psram_ce_n <= 1'b1;
                     rd_data    <= {rx_sh, psram_sio_in};
                     send_uart  <= 1'b1;
                     wait_cnt   <= '0;
                     state      <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               if (wait_cnt == GAP_TC) begin
                  wait_cnt <= '0;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            default: begin
               psram_ce_n   <= 1'b1;
               psram_sio_oe <= 4'h0;
               busy         <= 1'b1;
               init_done    <= 1'b0;
               init_idx     <= '0;
               wait_cnt     <= '0;
               state        <= S_INIT_WAIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psram_quad_ctrl.sv
// Testbench for psram_quad_ctrl: a PSRAM bus emulator decodes every ce_n frame
// and serves read data from its own memory; a reference model updated at
// request time predicts frames, read data and write completions.
module tb_psram_quad_ctrl;
   localparam int INIT_CYCLES    = 10;
   localparam int READ_WAIT_CLKS = 6;
   localparam int CE_HIGH_MIN    = 2;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        quad_start = 1'b0;
   logic        cmd_read = 1'b0;
   logic [22:0] address = '0;
   logic [15:0] wr_data = '0;
   logic [15:0] rd_data;
   logic        send_uart, wr_done, busy, init_done;
   logic        psram_ce_n, psram_sclk;
   logic [3:0]  psram_sio_out, psram_sio_oe;
   logic [3:0]  psram_sio_in;

   psram_quad_ctrl #(
      .INIT_CYCLES(INIT_CYCLES), .READ_WAIT_CLKS(READ_WAIT_CLKS), .CE_HIGH_MIN(CE_HIGH_MIN)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .quad_start(quad_start),
      .cmd_read(cmd_read), .address(address), .wr_data(wr_data),
      .rd_data(rd_data), .send_uart(send_uart), .wr_done(wr_done),
      .busy(busy), .init_done(init_done), .psram_ce_n(psram_ce_n),
      .psram_sclk(psram_sclk), .psram_sio_out(psram_sio_out),
      .psram_sio_oe(psram_sio_oe), .psram_sio_in(psram_sio_in)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int          kind;   // 0 init opcode, 1 write, 2 read
      logic [22:0] addr;
      logic [15:0] data;
   } frame_t;

   int errors = 0;
   int checks = 0;

   frame_t      exp_frames[$];
   logic [15:0] exp_rd_q[$];
   logic [15:0] exp_wr_q[$];
   logic [7:0]  ref_mem[logic [22:0]];
   logic [7:0]  psr_mem[logic [22:0]];
   logic [15:0] last_rd = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] dflt(input logic [22:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [22:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return dflt(a);
   endfunction

   function automatic logic [7:0] psr_rd(input logic [22:0] a);
      if (psr_mem.exists(a)) return psr_mem[a];
      return dflt(a);
   endfunction

   // ---------------- PSRAM bus emulator + frame monitor ----------------
   int unsigned rises, low_cyc, gap;
   int unsigned hi_cnt = 1000;
   int          sclk_idle_err = 0;
   bit          in_frame = 0, prev_sclk = 0, em_read = 0;
   logic [63:0] cap;
   logic [3:0]  oe_seq[$];
   logic [22:0] em_addr;
   logic [15:0] em_data;

   task automatic end_frame();
      frame_t     f;
      logic [3:0] exp_oe;
      int         n_exp;
      bit         oe_ok = 1;
      logic [22:0] wa;
      if (rises == 12 && oe_seq.size() > 0 && oe_seq[0] == 4'hF && cap[47:40] == 8'h38) begin
         wa = cap[38:16];
         psr_mem[wa] = cap[15:8];
         psr_mem[23'(wa + 23'd1)] = cap[7:0];
      end
      if (exp_frames.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_frame: got a frame of %0d sclks, expected no frame", rises);
         return;
      end
      f = exp_frames.pop_front();
      n_exp = (f.kind == 0) ? 8 : (f.kind == 1) ? 12 : 12 + READ_WAIT_CLKS;
      check("frame_sclks", 64'(rises), 64'(n_exp));
      check("frame_ce_low_cycles", 64'(low_cyc), 64'(2 * n_exp));
      check("frame_ce_gap_ok", 64'(gap >= CE_HIGH_MIN), 64'd1);
      for (int i = 0; i < oe_seq.size(); i++) begin
         if (f.kind == 0)      exp_oe = 4'b0001;
         else if (f.kind == 1) exp_oe = 4'hF;
         else                  exp_oe = (i < 8) ? 4'hF : 4'h0;
         if (oe_seq[i] !== exp_oe) oe_ok = 0;
      end
      check("frame_oe", 64'(oe_ok), 64'd1);
      case (f.kind)
         0: begin
            check("init_byte", 64'(cap[7:0]), 64'(f.data[7:0]));
            check("init_done_during_init", 64'(init_done), 64'd0);
         end
         1: begin
            check("write_nibbles", cap[47:0], {16'h0, 8'h38, 1'b0, f.addr, f.data});
            check("init_done_in_txn", 64'(init_done), 64'd1);
         end
         default: begin
            check("read_header", 64'(cap[31:0]), {32'h0, 8'hEB, 1'b0, f.addr});
            check("init_done_in_txn", 64'(init_done), 64'd1);
         end
      endcase
   endtask

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         in_frame     = 0;
         prev_sclk    = 0;
         em_read      = 0;
         hi_cnt       = 1000;
         psram_sio_in = 4'($urandom);
      end else begin
         if (psram_ce_n && psram_sclk) sclk_idle_err++;
         if (!psram_ce_n) begin
            if (!in_frame) begin
               in_frame = 1; low_cyc = 0; rises = 0; cap = '0; gap = hi_cnt; em_read = 0;
               oe_seq.delete();
            end
            low_cyc++;
            if (psram_sclk && !prev_sclk) begin
               rises++;
               oe_seq.push_back(psram_sio_oe);
               if (psram_sio_oe == 4'b0001)  cap = {cap[62:0], psram_sio_out[0]};
               else if (psram_sio_oe == 4'hF) cap = {cap[59:0], psram_sio_out};
               if (rises == 8 && psram_sio_oe == 4'hF && cap[31:24] == 8'hEB) begin
                  em_read = 1;
                  em_addr = cap[22:0];
                  em_data = {psr_rd(em_addr), psr_rd(23'(em_addr + 23'd1))};
               end
            end
            // Data changes only while SCLK is low, as a real PSRAM would.
            if (!psram_sclk) begin
               if (em_read && rises >= 8 + READ_WAIT_CLKS && rises < 12 + READ_WAIT_CLKS)
                  psram_sio_in = 4'(em_data >> (12 - 4 * (rises - (8 + READ_WAIT_CLKS))));
               else
                  psram_sio_in = 4'($urandom);
            end
            hi_cnt = 0;
         end else begin
            if (in_frame) begin
               in_frame = 0;
               end_frame();
            end
            hi_cnt++;
            psram_sio_in = 4'($urandom);
         end
         prev_sclk = psram_sclk;
      end
   end

   // ---------------- output monitor ----------------
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (send_uart) begin
            if (exp_rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_send_uart: got pulse with rd_data=%h, expected no pulse", rd_data);
            end else check("rd_data", 64'(rd_data), 64'(exp_rd_q.pop_front()));
         end
         if (wr_done) begin
            if (exp_wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_wr_done: got pulse, expected no pulse");
            end else check("rd_data_hold_on_write", 64'(rd_data), 64'(exp_wr_q.pop_front()));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic push_init();
      frame_t f;
      logic [7:0] ops [3];
      ops = '{8'h66, 8'h99, 8'h35};
      for (int i = 0; i < 3; i++) begin
         f.kind = 0; f.addr = '0; f.data = {8'h00, ops[i]};
         exp_frames.push_back(f);
      end
   endtask

   task automatic drive_req(input bit rd, input logic [22:0] a, input logic [15:0] d);
      quad_start = 1'b1; cmd_read = rd; address = a; wr_data = d;
      @(negedge sys_clk);
      quad_start = 1'b0; cmd_read = 1'($urandom); address = 23'($urandom); wr_data = 16'($urandom);
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge sys_clk);
         if (!busy) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL busy_timeout: busy still 1, expected 0 within 400 cycles");
      end
   endtask

   task automatic wait_ce(input logic v);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (psram_ce_n === v) begin ok = 1; break; end
         @(negedge sys_clk);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL ce_timeout: ce_n never reached %0b", v);
      end
   endtask

   task automatic wait_init();
      bit ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge sys_clk);
         if (init_done) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL init_timeout: init_done still 0 after 2000 cycles, expected 1");
      end
      check("busy_after_init", 64'(busy), 64'd0);
   endtask

   task automatic issue(input bit rd, input logic [22:0] a, input logic [15:0] d);
      bit ok;
      frame_t f;
      wait_idle(ok);
      if (!ok) return;
      f.kind = rd ? 2 : 1; f.addr = a; f.data = d;
      if (rd) begin
         last_rd = {ref_rd(a), ref_rd(23'(a + 23'd1))};
         exp_rd_q.push_back(last_rd);
      end else begin
         ref_mem[a] = d[15:8];
         ref_mem[23'(a + 23'd1)] = d[7:0];
         exp_wr_q.push_back(last_rd);
      end
      exp_frames.push_back(f);
      drive_req(rd, a, d);
   endtask

   initial begin
      bit ok;
      #12;
      check("rst_ce_n", 64'(psram_ce_n), 64'd1);
      check("rst_sclk", 64'(psram_sclk), 64'd0);
      check("rst_sio_out", 64'(psram_sio_out), 64'd0);
      check("rst_sio_oe", 64'(psram_sio_oe), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_send_uart", 64'(send_uart), 64'd0);
      check("rst_wr_done", 64'(wr_done), 64'd0);
      check("rst_busy", 64'(busy), 64'd1);
      check("rst_init_done", 64'(init_done), 64'd0);
      push_init();
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("busy_in_init_wait", 64'(busy), 64'd1);
      drive_req(1'b1, 23'h000123, 16'h0000);           // ignored: still initialising
      wait_init();

      issue(1'b0, 23'h000123, 16'hBEEF);
      issue(1'b1, 23'h000123, 16'h0000);
      issue(1'b1, 23'h000456, 16'h0000);
      repeat (10) @(negedge sys_clk);
      drive_req(1'b0, 23'h000001, 16'h1234);            // ignored: read in flight

      // Request landing on the edge where busy falls must be dropped.
      issue(1'b0, 23'h000200, 16'hCAFE);
      wait_ce(1'b0);
      wait_ce(1'b1);
      @(negedge sys_clk);
      check("busy_in_ce_recovery", 64'(busy), 64'd1);
      drive_req(1'b1, 23'h000200, 16'h0000);
      check("busy_after_recovery", 64'(busy), 64'd0);

      issue(1'b0, 23'h7FFFFF, 16'h1357);
      issue(1'b1, 23'h7FFFFF, 16'h0000);
      issue(1'b1, 23'h000000, 16'h0000);
      issue(1'b1, 23'h000200, 16'h0000);                // back-to-back reads
      issue(1'b1, 23'h000123, 16'h0000);

      for (int i = 0; i < 40; i++) begin
         logic [22:0] a;
         a = ($urandom_range(0, 3) == 0) ? 23'($urandom) : 23'($urandom_range(0, 31));
         issue(1'($urandom), a, 16'($urandom));
      end

      // Reset in the middle of a write's address phase.
      wait_idle(ok);
      drive_req(1'b0, 23'h000123, 16'h0BAD);
      repeat (6) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      check("abort_ce_n", 64'(psram_ce_n), 64'd1);
      check("abort_sio_oe", 64'(psram_sio_oe), 64'd0);
      check("abort_busy", 64'(busy), 64'd1);
      check("abort_init_done", 64'(init_done), 64'd0);
      exp_frames.delete();
      last_rd = '0;
      push_init();
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      wait_init();
      issue(1'b1, 23'h000123, 16'h0000);
      issue(1'b1, 23'h7FFFFF, 16'h0000);

      for (int i = 0; i < 500; i++) begin
         if (exp_frames.size() == 0 && exp_rd_q.size() == 0 && exp_wr_q.size() == 0 && !busy) break;
         @(negedge sys_clk);
      end
      repeat (4) @(negedge sys_clk);
      check("pending_frames", 64'(exp_frames.size()), 64'd0);
      check("pending_reads", 64'(exp_rd_q.size()), 64'd0);
      check("pending_writes", 64'(exp_wr_q.size()), 64'd0);
      check("sclk_low_while_ce_high", 64'(sclk_idle_err), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/psram_quad_ctrl.md
Name: psram_quad_ctrl

Overview:
- Quad-SPI (QPI) controller for the 64 Mbit APS6404L-class PSRAM; sits directly downstream of the UART command parser.
- Accepts single 16-bit read or write requests via a one-cycle start pulse plus a 23-bit address.
- Performs power-up init, runs the QPI transaction and returns read data to the UART transmitter through a one-cycle send pulse.

Parameters:
- INIT_CYCLES, 4050, sys_clk cycles of power-up wait before the first command (150 us at 27 MHz).
- READ_WAIT_CLKS, 6, SCLK wait cycles between address and read data for command 0xEB.
- CE_HIGH_MIN, 2, minimum sys_clk cycles ce_n held high between transactions and between init commands.

Ports:
- sys_clk  in  1  system clock, 27 MHz; all logic on posedge.
- sys_rst_n  in  1  asynchronous active-low reset.
- quad_start  in  1  one-cycle request pulse.
- cmd_read  in  1  sampled with quad_start: 1 = read, 0 = write.
- address  in  23  PSRAM byte address, sampled with quad_start.
- wr_data  in  16  write data, sampled with quad_start.
- rd_data  out  16  last read result.
- send_uart  out  1  one-cycle pulse when rd_data is updated.
- wr_done  out  1  one-cycle pulse at write completion.
- busy  out  1  high during init, transaction and CE recovery.
- init_done  out  1  high once the PSRAM is in QPI mode.
- psram_ce_n  out  1  chip enable, active low.
- psram_sclk  out  1  SPI clock, sys_clk/2.
- psram_sio_out  out  4  data driven to the PSRAM.
- psram_sio_oe  out  4  per-bit output enable; tristate buffers live at top level.
- psram_sio_in  in  4  data from the PSRAM.

Behaviour:
Reset values (asynchronous, sys_rst_n low):
- ce_n=1, sclk=0, sio_out=0, sio_oe=0, rd_data=0.
- send_uart=0, wr_done=0, busy=1, init_done=0; state=INIT_WAIT, counters cleared.
- Reset mid-transaction aborts immediately (ce_n high that cycle) and restarts the full init.

SCLK phase:
- A phase bit toggles every sys_clk while ce_n is low.
- Phase 0: sclk=0, drive the next bit or nibble.
- Phase 1: sclk=1; psram_sio_in is sampled on the sys_clk edge ending phase 1.
- One SCLK = 2 sys_clk. sclk=0 whenever ce_n=1.

States:
- INIT_WAIT: count INIT_CYCLES, then go to INIT_CMD.
- INIT_CMD: SPI mode, 1 bit per SCLK on sio[0], sio_oe=4'b0001, MSB first. Send 0x66, then 0x99, then 0x35. Each command is 8 SCLK (16 cycles) followed by CE_HIGH_MIN cycles with ce_n high. After 0x35: init_done=1, busy=0, go to IDLE.
- IDLE: quad_start=1 latches cmd_read, {1'b0,address}, wr_data; sets busy=1; ce_n low next cycle; go to CMD.
- CMD: QPI, sio_oe=4'hF, 2 nibbles, MSB first. Opcode 0xEB for read, 0x38 for write.
- ADDR: 6 nibbles of the 24-bit address, MSB first. Next state: WAIT on read, WR_DATA on write.
- WAIT (read only): READ_WAIT_CLKS SCLKs, sio_oe=0.
- WR_DATA: 4 nibbles, wr_data[15:12] first; wr_data[15:8] is the byte at address.
- RD_DATA: sio_oe=0; 4 nibbles shifted in, first nibble into bits [15:12].
- DONE: ce_n=1 immediately after the last SCLK falls.
  - Read: rd_data updated and send_uart=1 in the first ce_n-high cycle.
  - Write: wr_done=1 in the same cycle.
  - After CE_HIGH_MIN cycles, busy=0 and return to IDLE.

Timing (ce_n low duration):
- Write: 12 SCLK = 24 cycles.
- Read (default parameters): 18 SCLK = 36 cycles.

Boundary conditions:
- quad_start while busy (including before init_done) is ignored; no queuing.
- quad_start in the same cycle busy falls is also ignored.
- Address 23'h7FFFFF: two-byte access relies on PSRAM internal wrap; no special handling.
- rd_data holds until the next completed read; a write never changes rd_data.
- quad_start is produced on negedge in the upstream block; it is sampled here on posedge with no resynchronisation (same clock).

Test Plan:
- Reset release with INIT_CYCLES=10 -> after 10 cycles, sio[0] serialises 0x66, 0x99, 0x35; ce_n high ≥2 cycles between commands; init_done=1 only after 0x35.
- Write address=23'h000123, wr_data=16'hBEEF -> nibbles 3,8,0,0,0,1,2,3,B,E,E,F on sio_out with sio_oe=F; ce_n low 24 cycles; wr_done single pulse; send_uart stays 0.
- Read address=23'h000123 with a PSRAM model returning 16'hBEEF -> nibbles E,B then address; sio_oe=0 for 6 wait SCLK + 4 data SCLK; rd_data=16'hBEEF; send_uart one pulse; ce_n low 36 cycles.
- quad_start pulsed mid-read and again during INIT_WAIT -> no extra transaction; only one send_uart per accepted read.
- sys_rst_n asserted during ADDR of a write -> ce_n=1 and sio_oe=0 immediately; wr_done never pulses; full init sequence repeats.
- Back-to-back reads issued on the first cycle busy=0 -> both complete; ce_n high ≥ CE_HIGH_MIN between them; rd_data updates twice.
